// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-issue integer execute unit (ADD/SUB/logic/SLT/shifts).
// Optional macro ALU_EXEC_MUL_EN builds an iterative shift-add unsigned MUL on
// ctrl 4'b1000; without it that code is reported as illegal and the unit never
// stalls.
module alu_exec_unit #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        ctrl,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] result_hi,
    output logic              zero,
    output logic              ovf,
    output logic              illegal
);

    localparam int unsigned MSB = DATA_W - 1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLT = 4'b0101;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b0111;

`ifdef ALU_EXEC_MUL_EN
    localparam logic [3:0]  OP_MUL = 4'b1000;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned PW     = 2 * DATA_W;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [PW-1:0]     acc, acc_d, acc_step;
    logic [PW-1:0]     mcand, mcand_d;
    logic [DATA_W-1:0] mplier, mplier_d;

    assign in_ready = (state == S_IDLE);
`else
    assign in_ready = 1'b1;
`endif

    logic [DATA_W-1:0] sum, diff, b_neg, alu_res;
    logic              alu_ovf, alu_ill;
    logic [3:0]        shamt;
    logic [DATA_W-1:0] result_d, result_hi_d;
    logic              out_valid_d, zero_d, ovf_d, illegal_d;

    assign sum   = a + b;
    assign b_neg = ~b + DATA_W'(1);
    assign diff  = a + b_neg;
    assign shamt = b[3:0];

    // Single-cycle ALU result, overflow and illegal-code decode.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (ctrl)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[MSB] == b_neg[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = DATA_W'($signed(a) < $signed(b));
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            default: alu_ill = 1'b1;
        endcase
    end

    // Next-state and output logic: accept in IDLE, one shift-add step per cycle in MUL.
    always_comb begin
        out_valid_d = 1'b0;
        result_d    = result;
        result_hi_d = result_hi;
        zero_d      = zero;
        ovf_d       = ovf;
        illegal_d   = illegal;
`ifdef ALU_EXEC_MUL_EN
        state_d  = state;
        cnt_d    = cnt;
        acc_d    = acc;
        mcand_d  = mcand;
        mplier_d = mplier;
        acc_step = acc + (mplier[0] ? mcand : '0);

        if (state == S_MUL) begin
            acc_d    = acc_step;
            mcand_d  = mcand << 1;
            mplier_d = mplier >> 1;
            cnt_d    = cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) begin
                {result_hi_d, result_d} = acc_step;
                zero_d      = (acc_step[DATA_W-1:0] == '0);
                ovf_d       = 1'b0;
                illegal_d   = 1'b0;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
        end else if (in_valid && (ctrl == OP_MUL)) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = PW'(a);
            mplier_d = b;
        end else
`endif
        if (in_valid) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            result_hi_d = '0;
            zero_d      = (alu_res == '0);
            ovf_d       = alu_ovf;
            illegal_d   = alu_ill;
        end
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
`endif
        end else begin
            out_valid <= out_valid_d;
            result    <= result_d;
            result_hi <= result_hi_d;
            zero      <= zero_d;
            ovf       <= ovf_d;
            illegal   <= illegal_d;
`ifdef ALU_EXEC_MUL_EN
            state     <= state_d;
            cnt       <= cnt_d;
            acc       <= acc_d;
            mcand     <= mcand_d;
            mplier    <= mplier_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vector table plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_alu_exec_unit;

    localparam int unsigned W = 16;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zero;
    logic         ovf;
    logic         illegal;

    typedef struct {
        string        name;
        logic [3:0]   ctrl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         o;
        logic         ill;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_miss;

    alu_exec_unit #(.DATA_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string n, input logic [3:0] c, input logic [W-1:0] av,
                           input logic [W-1:0] bv, input logic [W-1:0] r,
                           input logic z, input logic o, input logic il);
        vec_t v;
        v.name = n; v.ctrl = c; v.a = av; v.b = bv;
        v.res = r; v.z = z; v.o = o; v.ill = il;
        vecs.push_back(v);
    endtask

    task automatic check_result(input string n, input logic [W-1:0] r, input logic [W-1:0] hi,
                                input logic z, input logic o, input logic il);
        chk({n, ".out_valid"}, 32'(out_valid), 32'(1));
        chk({n, ".result"},    32'(result),    32'(r));
        chk({n, ".result_hi"}, 32'(result_hi), 32'(hi));
        chk({n, ".zero"},      32'(zero),      32'(z));
        chk({n, ".ovf"},       32'(ovf),       32'(o));
        chk({n, ".illegal"},   32'(illegal),   32'(il));
    endtask

    task automatic check_all_zero(input string n);
        chk({n, ".out_valid"}, 32'(out_valid), 32'(0));
        chk({n, ".result"},    32'(result),    32'(0));
        chk({n, ".result_hi"}, 32'(result_hi), 32'(0));
        chk({n, ".zero"},      32'(zero),      32'(0));
        chk({n, ".ovf"},       32'(ovf),       32'(0));
        chk({n, ".illegal"},   32'(illegal),   32'(0));
        chk({n, ".in_ready"},  32'(in_ready),  32'(1));
    endtask

    initial begin
        int pulses;
`ifdef ALU_EXEC_MUL_EN
        int busy_bad;
        int lat;
        bit got;
`endif
        n_vec    = 0;
        n_miss   = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        ctrl     = 4'b0000;
        a        = '0;
        b        = '0;
        #1 reset = 1'b1;
        #1 check_all_zero("reset_init");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        //          name          ctrl     a         b         res       z     o     ill
        add_vec("add_ovf",     4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0);
        add_vec("sub_eq",      4'b0001, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0);
        add_vec("add_wrap",    4'b0000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
        add_vec("sub_ovf",     4'b0001, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        add_vec("sub_minneg",  4'b0001, 16'h0000, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
        add_vec("and",         4'b0010, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0);
        add_vec("or",          4'b0011, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        add_vec("xor_self",    4'b0100, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 1'b0);
        add_vec("slt_false",   4'b0101, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
        add_vec("slt_true",    4'b0101, 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        add_vec("sll_0",       4'b0110, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0);
        add_vec("sll_15",      4'b0110, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b0);
        add_vec("sll_b_hi",    4'b0110, 16'h00FF, 16'h0014, 16'h0FF0, 1'b0, 1'b0, 1'b0);
        add_vec("srl_15",      4'b0111, 16'hFFFF, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0);
`ifndef ALU_EXEC_MUL_EN
        add_vec("mul_illegal", 4'b1000, 16'h0003, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b1);
`endif
        add_vec("ill_1010",    4'b1010, 16'h1111, 16'h2222, 16'h0000, 1'b1, 1'b0, 1'b1);
        add_vec("ill_1111",    4'b1111, 16'h1234, 16'h5678, 16'h0000, 1'b1, 1'b0, 1'b1);

        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = 1'b1;
            ctrl     = vecs[i].ctrl;
            a        = vecs[i].a;
            b        = vecs[i].b;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check_result(vecs[i].name, vecs[i].res, 16'h0000, vecs[i].z, vecs[i].o, vecs[i].ill);
        end

        // out_valid is a single pulse; outputs hold afterwards
        @(posedge clk);
        #1;
        chk("hold.out_valid", 32'(out_valid), 32'(0));
        chk("hold.illegal",   32'(illegal),   32'(1));
        chk("hold.zero",      32'(zero),      32'(1));

        // back-to-back SLT then SRL with in_valid held high
        @(negedge clk);
        in_valid = 1'b1;
        ctrl = 4'b0101; a = 16'hFFFF; b = 16'h0001;
        @(posedge clk);
        #1;
        check_result("b2b_slt", 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("b2b_slt.in_ready", 32'(in_ready), 32'(1));
        ctrl = 4'b0111; a = 16'h8000; b = 16'h000F;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_result("b2b_srl", 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("b2b_end.out_valid", 32'(out_valid), 32'(0));

`ifdef ALU_EXEC_MUL_EN
        // MUL FFFF*FFFF with in_valid held high during the busy window
        @(negedge clk);
        in_valid = 1'b1;
        ctrl = 4'b1000; a = 16'hFFFF; b = 16'hFFFF;
        @(posedge clk);
        #1;
        ctrl = 4'b0000; a = 16'h0001; b = 16'h0001;
        busy_bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) busy_bad++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("mul_ffff.busy_cycles_bad", 32'(busy_bad), 32'(0));
        check_result("mul_ffff", 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        chk("mul_ffff.in_ready", 32'(in_ready), 32'(1));

        // MUL 3*5 latency measured with a bounded wait
        @(negedge clk);
        in_valid = 1'b1;
        ctrl = 4'b1000; a = 16'h0003; b = 16'h0005;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                got = 1'b1;
                lat = i;
            end
        end
        chk("mul_3x5.latency", 32'(lat), 32'(16));
        check_result("mul_3x5", 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0);
`endif

        // reset in the middle of an operation
        @(negedge clk);
        in_valid = 1'b1;
`ifdef ALU_EXEC_MUL_EN
        ctrl = 4'b1000; a = 16'h1234; b = 16'h5678;
`else
        ctrl = 4'b0000; a = 16'h1111; b = 16'h2222;
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`ifdef ALU_EXEC_MUL_EN
        repeat (7) @(posedge clk);
`endif
        #2 reset = 1'b1;
        #1 check_all_zero("reset_mid");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_release.in_ready", 32'(in_ready), 32'(1));
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) pulses++;
        end
        chk("reset_release.stray_pulses", 32'(pulses), 32'(0));

        @(negedge clk);
        in_valid = 1'b1;
        ctrl = 4'b0000; a = 16'h0002; b = 16'h0003;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_result("post_reset_add", 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The module SHALL have parameter DATA_W, default 16, the operand and result width.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: the operation request.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the unit can accept an operation.
REQ-006 The module SHALL have port ctrl, input, 4 bits: the operation code produced by the upstream ALU control decoder.
REQ-007 The module SHALL have ports a and b, input, DATA_W bits each: the operands.
REQ-008 The module SHALL have port out_valid, output, 1 bit: a one-cycle pulse marking a valid result.
REQ-009 The module SHALL have port result, output, DATA_W bits: the result, which is the low half for MUL.
REQ-010 The module SHALL have port result_hi, output, DATA_W bits: the MUL high half, zero for all other operations.
REQ-011 The module SHALL have port zero, output, 1 bit: result is equal to 0.
REQ-012 The module SHALL have port ovf, output, 1 bit: signed overflow for ADD/SUB, 0 for all other operations.
REQ-013 The module SHALL have port illegal, output, 1 bit: ctrl was an unsupported code.

Function
REQ-014 The ctrl encoding SHALL be 0000 ADD, 0001 SUB (a-b), 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed, 1/0), 0110 SLL by b[3:0], 0111 SRL by b[3:0], 1000 MUL (unsigned, iterative), and 1001-1111 illegal.
REQ-015 An operation SHALL be accepted on a rising edge where in_valid is 1 and in_ready is 1, and a, b and ctrl SHALL be sampled only on that edge.
REQ-016 The FSM SHALL have two states, IDLE and MUL, with in_ready equal to 1 exactly when the state is IDLE.
REQ-017 On accepting any non-MUL code, the unit SHALL register result, result_hi, zero, ovf and illegal on the accepting edge and drive out_valid=1 for the following cycle, giving a latency of 1 cycle.
REQ-018 On accepting an illegal code, the unit SHALL produce result=0, zero=1, illegal=1 and out_valid with 1-cycle latency.
REQ-019 On accepting MUL, the unit SHALL enter state MUL with a 5-bit iteration counter of 0, a product accumulator of 0 and the multiplicand/multiplier latched.
REQ-020 In state MUL the unit SHALL perform one shift-add step per cycle for DATA_W cycles.
REQ-021 On the DATA_W-th step edge the unit SHALL write {result_hi,result} = a*b (2*DATA_W bits), set out_valid=1 for one cycle, and return to IDLE.
REQ-022 The MUL latency SHALL be DATA_W cycles from the accept edge to out_valid, which is 16 cycles at the default width.
REQ-023 In state MUL, in_valid SHALL be ignored and outputs SHALL hold their previous values.
REQ-024 out_valid SHALL be 1 only in the cycle after a completing edge; an op accepted in that same cycle (back-to-back) SHALL be legal, so a single-cycle op gives out_valid high again the next cycle.
REQ-025 Arithmetic SHALL be modulo 2^DATA_W, with carry-out discarded.
REQ-026 ovf SHALL be (a[msb]==b'[msb]) && (res[msb]!=a[msb]), where b'=b for ADD and b'=~b+1 for SUB.
REQ-027 A shift amount of 0 SHALL pass a unchanged, and a shift amount of 15 SHALL leave only one source bit.

Reset
REQ-028 When reset is asserted, state SHALL be IDLE, and out_valid, result, result_hi, zero, ovf, illegal, the counter and the accumulator SHALL all be 0, immediately and without waiting for clk.
REQ-029 zero SHALL reset to 0 and is defined only when out_valid is 1 or held since then.
REQ-030 Reset asserted mid-MUL SHALL abort the operation with no out_valid pulse, and in_ready SHALL be 1 in the first cycle after deassertion.

Configuration
REQ-031 With macro ALU_EXEC_MUL_EN defined, code 1000 SHALL be MUL as in REQ-019 to REQ-022.
REQ-032 Without ALU_EXEC_MUL_EN, code 1000 SHALL be treated as illegal per REQ-018, state MUL and its counter/accumulator SHALL not be built, and in_ready SHALL be constantly 1 outside reset.

Verification
REQ-033 The bench SHALL apply ADD a=16'h7FFF, b=16'h0001 and require, 1 cycle later, out_valid=1, result=16'h8000, ovf=1, zero=0.
REQ-034 The bench SHALL apply SUB a=16'h1234, b=16'h1234 and require result=16'h0000, zero=1, ovf=0.
REQ-035 The bench SHALL apply, with ALU_EXEC_MUL_EN defined, MUL a=16'hFFFF, b=16'hFFFF and require in_ready=0 for 16 cycles, then out_valid with result=16'h0001 and result_hi=16'hFFFE, with in_valid held high during busy ignored.
REQ-036 The bench SHALL apply SLT a=16'hFFFF, b=16'h0001 back-to-back with SRL a=16'h8000, b=16'h000F and require consecutive out_valid pulses with result=1, then result=16'h0001.
REQ-037 The bench SHALL apply ctrl=4'b1111 and require result=0, illegal=1, zero=1, and with ALU_EXEC_MUL_EN undefined require ctrl=4'b1000 to give the same response.
REQ-038 The bench SHALL start a MUL, assert reset at iteration 7, and require all outputs to be 0, no out_valid pulse, and in_ready=1 after deassertion, after which an ADD 2+3 SHALL return 5.
